// File: rtl/letc_core_stage_f2.sv
// LETC core fetch stage 2: issues the instruction memory request for the
// address captured from F1, waits for the single response and presents the
// fetched instruction word to decode. Flushes drain any outstanding request
// so that a stale response can never be mistaken for a new one.

package letc_pkg;
    typedef logic [31:0] word_t;
    typedef logic [31:0] paddr_t;
endpackage

package letc_core_pkg;
    import letc_pkg::*;

    typedef logic [29:0] pc_word_t;
    typedef logic [29:0] instr_t;

    typedef struct packed {
        logic     valid;
        pc_word_t pc_word;
        paddr_t   fetch_addr;
    } f1_to_f2_s;

    typedef struct packed {
        logic     valid;
        pc_word_t pc_word;
        instr_t   instr;
    } f2_to_d_s;
endpackage

module letc_core_stage_f2
    import letc_pkg::*;
    import letc_core_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,

    input  f1_to_f2_s                    f1_to_f2,
    output logic                         f2_ready,

    output f2_to_d_s                     f2_to_d,
    input  logic                         d_ready,

    input  logic                         flush,

    output logic                         imem_req_valid,
    output logic [$bits(paddr_t)-1:0]    imem_req_addr,
    input  logic                         imem_req_ready,
    input  logic                         imem_rsp_valid,
    input  logic [$bits(word_t)-1:0]     imem_rsp_data
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN_REQ,
        DRAIN_RSP
    } state_e;

    state_e   state;
    pc_word_t pc_word_q;
    paddr_t   fetch_addr_q;
    logic     accept;

    // The two low bits of an instruction word are implied and not forwarded.
    logic     unused_rsp_low_bits;
    assign unused_rsp_low_bits = ^imem_rsp_data[1:0];

    assign imem_req_addr = fetch_addr_q;

    // Ready to take a new fetch when empty, or when decode is draining the held word.
    always_comb begin
        f2_ready = ((state == IDLE) | ((state == HOLD) & d_ready)) & ~flush;
        accept   = f1_to_f2.valid & f2_ready;
    end

    // Fetch FSM; every output except f2_ready is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            pc_word_q       <= '0;
            fetch_addr_q    <= '0;
            imem_req_valid  <= 1'b0;
            f2_to_d         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pc_word_q      <= f1_to_f2.pc_word;
                        fetch_addr_q   <= f1_to_f2.fetch_addr;
                        imem_req_valid <= 1'b1;
                        state          <= REQ;
                    end
                end

                REQ: begin
                    if (flush) begin
                        // An accepted request must still see its response drained.
                        if (imem_req_ready) begin
                            imem_req_valid <= 1'b0;
                            state          <= DRAIN_RSP;
                        end else begin
                            state          <= DRAIN_REQ;
                        end
                    end else if (imem_req_ready) begin
                        imem_req_valid <= 1'b0;
                        state          <= WAIT;
                    end
                end

                WAIT: begin
                    if (flush) begin
                        state <= imem_rsp_valid ? IDLE : DRAIN_RSP;
                    end else if (imem_rsp_valid) begin
                        f2_to_d.valid   <= 1'b1;
                        f2_to_d.pc_word <= pc_word_q;
                        f2_to_d.instr   <= imem_rsp_data[31:2];
                        state           <= HOLD;
                    end
                end

                HOLD: begin
                    if (flush) begin
                        f2_to_d.valid <= 1'b0;
                        state         <= IDLE;
                    end else if (d_ready) begin
                        f2_to_d.valid <= 1'b0;
                        if (accept) begin
                            pc_word_q      <= f1_to_f2.pc_word;
                            fetch_addr_q   <= f1_to_f2.fetch_addr;
                            imem_req_valid <= 1'b1;
                            state          <= REQ;
                        end else begin
                            state          <= IDLE;
                        end
                    end
                end

                DRAIN_REQ: begin
                    if (imem_req_ready) begin
                        imem_req_valid <= 1'b0;
                        state          <= DRAIN_RSP;
                    end
                end

                DRAIN_RSP: begin
                    if (imem_rsp_valid) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    imem_req_valid <= 1'b0;
                    f2_to_d.valid  <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_letc_core_stage_f2.sv
// Directed and randomized checks for the F2 fetch stage. The bench plays the
// instruction memory and tracks each fetch as a transaction.

module tb_letc_core_stage_f2;
    import letc_pkg::*;
    import letc_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    f1_to_f2_s   f1;
    logic        f2_ready;
    f2_to_d_s    f2d;
    logic        d_ready;
    logic        flush;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    int unsigned checks = 0;
    int unsigned errors = 0;

    localparam logic [31:0] A0 = 32'h8000_0000;

    letc_core_stage_f2 dut (
        .clk            (clk),
        .rst            (rst),
        .f1_to_f2       (f1),
        .f2_ready       (f2_ready),
        .f2_to_d        (f2d),
        .d_ready        (d_ready),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [29:0] pc, input logic [31:0] addr,
                         input logic dr, input logic rr, input logic rv,
                         input logic [31:0] rd, input logic fl);
        f1.valid       = v;
        f1.pc_word     = pc;
        f1.fetch_addr  = addr;
        d_ready        = dr;
        imem_req_ready = rr;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        flush          = fl;
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Transaction-level reference state for the randomized phase.
    logic        busy, have_req, rsp_got;
    logic [29:0] exp_pc;
    logic [31:0] exp_addr, rsp_addr, w, r;
    logic [29:0] exp_instr;
    int unsigned rsp_cnt;
    logic        v, dr, rr, rv, acc, hs, consume;
    logic [29:0] pc;
    logic [31:0] addr;

    initial begin
        rst = 1'b1;
        drive(0, '0, '0, 0, 0, 0, '0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        chk("rst_f2_ready", f2_ready, 1);
        chk("rst_valid", f2d.valid, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_pc", f2d.pc_word, 0);
        chk("rst_instr", f2d.instr, 0);

        // Back-to-back fetches with minimum latency
        drive(1, 30'h0, A0, 1, 1, 0, '0, 0);
        chk("b2b_accept0", f2_ready, 1);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        chk("b2b_req0", imem_req_valid, 1);
        chk("b2b_addr0", imem_req_addr, A0);
        chk("b2b_busy0", f2_ready, 0);
        tick();
        drive(0, '0, '0, 1, 1, 1, 32'h0000_0013, 0);
        chk("b2b_req0_done", imem_req_valid, 0);
        chk("b2b_nv_n2", f2d.valid, 0);
        tick();
        drive(1, 30'h1, A0 + 4, 1, 1, 0, '0, 0);
        chk("b2b_valid0", f2d.valid, 1);
        chk("b2b_pc0", f2d.pc_word, 0);
        chk("b2b_instr0", f2d.instr, 32'h0000_0013 >> 2);
        chk("b2b_accept1", f2_ready, 1);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        chk("b2b_drop0", f2d.valid, 0);
        chk("b2b_req1", imem_req_valid, 1);
        chk("b2b_addr1", imem_req_addr, A0 + 4);
        tick();
        drive(0, '0, '0, 1, 1, 1, 32'h0010_0093, 0);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        chk("b2b_valid1", f2d.valid, 1);
        chk("b2b_pc1", f2d.pc_word, 1);
        chk("b2b_instr1", f2d.instr, 32'h0010_0093 >> 2);
        tick();
        chk("b2b_idle", f2d.valid, 0);
        chk("b2b_ready_idle", f2_ready, 1);

        // Decode backpressure holds the output bit-stable
        drive(1, 30'h5, A0 + 8, 0, 1, 0, '0, 0);
        tick();
        drive(0, '0, '0, 0, 1, 0, '0, 0);
        tick();
        drive(0, '0, '0, 0, 1, 1, 32'hDEAD_BEEF, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 30'h6, A0 + 12, 0, 1, 0, '0, 0);
            chk("bp_valid", f2d.valid, 1);
            chk("bp_pc", f2d.pc_word, 5);
            chk("bp_instr", f2d.instr, 32'hDEAD_BEEF >> 2);
            chk("bp_ready", f2_ready, 0);
            chk("bp_no_req", imem_req_valid, 0);
            tick();
        end
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        chk("bp_release", f2d.valid, 1);
        tick();
        chk("bp_done", f2d.valid, 0);

        // Request stall keeps address constant
        drive(1, 30'h7, A0, 1, 0, 0, '0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, '0, 1, 0, 0, '0, 0);
            chk("stall_req", imem_req_valid, 1);
            chk("stall_addr", imem_req_addr, A0);
            tick();
        end
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        chk("stall_req_last", imem_req_valid, 1);
        chk("stall_addr_last", imem_req_addr, A0);
        tick();
        drive(0, '0, '0, 1, 1, 1, 32'h1234_5678, 0);
        chk("stall_req_gone", imem_req_valid, 0);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        chk("stall_valid", f2d.valid, 1);
        chk("stall_pc", f2d.pc_word, 7);
        chk("stall_instr", f2d.instr, 32'h1234_5678 >> 2);
        tick();

        // Flush in WAIT, response arrives two cycles later
        drive(1, 30'h8, A0 + 16, 1, 1, 0, '0, 0);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 1);
        chk("fw_ready_flush", f2_ready, 0);
        tick();
        drive(1, 30'h9, A0, 1, 1, 0, '0, 0);
        chk("fw_drain_ready", f2_ready, 0);
        chk("fw_drain_valid", f2d.valid, 0);
        tick();
        drive(1, 30'h9, A0, 1, 1, 1, 32'hFFFF_FFFF, 0);
        chk("fw_rsp_ready", f2_ready, 0);
        chk("fw_rsp_valid", f2d.valid, 0);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        chk("fw_after_valid", f2d.valid, 0);
        chk("fw_after_ready", f2_ready, 1);
        chk("fw_after_req", imem_req_valid, 0);

        // Flush in REQ without ready: drain request then response
        drive(1, 30'h9, A0 + 32'h40, 1, 0, 0, '0, 0);
        tick();
        drive(0, '0, '0, 1, 0, 0, '0, 1);
        chk("fr_req", imem_req_valid, 1);
        tick();
        drive(0, '0, '0, 1, 0, 0, '0, 0);
        chk("fr_dreq", imem_req_valid, 1);
        chk("fr_daddr", imem_req_addr, A0 + 32'h40);
        chk("fr_dready", f2_ready, 0);
        chk("fr_dvalid", f2d.valid, 0);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 1);
        chk("fr_dreq2", imem_req_valid, 1);
        chk("fr_daddr2", imem_req_addr, A0 + 32'h40);
        tick();
        drive(1, 30'hA, A0, 1, 1, 1, 32'hCAFE_F00D, 0);
        chk("fr_drsp_req", imem_req_valid, 0);
        chk("fr_drsp_ready", f2_ready, 0);
        chk("fr_drsp_valid", f2d.valid, 0);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        chk("fr_end_valid", f2d.valid, 0);
        chk("fr_end_ready", f2_ready, 1);

        // Flush in REQ with ready goes straight to response drain
        drive(1, 30'hB, A0, 1, 1, 0, '0, 0);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 1);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        chk("frr_req", imem_req_valid, 0);
        chk("frr_ready", f2_ready, 0);
        tick();
        drive(0, '0, '0, 1, 1, 1, 32'h0, 0);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        chk("frr_idle", f2_ready, 1);
        chk("frr_valid", f2d.valid, 0);

        // Flush in WAIT coincident with the response discards it
        drive(1, 30'hC, A0, 1, 1, 0, '0, 0);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        tick();
        drive(0, '0, '0, 1, 1, 1, 32'h1111_1111, 1);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        chk("fwr_valid", f2d.valid, 0);
        chk("fwr_ready", f2_ready, 1);

        // Flush in HOLD overrides a simultaneous accept
        drive(1, 30'hD, A0, 0, 1, 0, '0, 0);
        tick();
        drive(0, '0, '0, 0, 1, 0, '0, 0);
        tick();
        drive(0, '0, '0, 0, 1, 1, 32'h2222_2222, 0);
        tick();
        drive(1, 30'hE, A0 + 4, 1, 1, 0, '0, 1);
        chk("fh_valid_before", f2d.valid, 1);
        chk("fh_ready", f2_ready, 0);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        chk("fh_valid", f2d.valid, 0);
        chk("fh_no_req", imem_req_valid, 0);
        chk("fh_idle", f2_ready, 1);

        // Flush in IDLE blocks accept
        drive(1, 30'hF, A0, 1, 1, 0, '0, 1);
        chk("fi_ready", f2_ready, 0);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        chk("fi_no_req", imem_req_valid, 0);

        // Asynchronous reset while holding a word
        drive(1, 30'h10, A0, 0, 1, 0, '0, 0);
        tick();
        drive(0, '0, '0, 0, 1, 0, '0, 0);
        tick();
        drive(0, '0, '0, 0, 1, 1, 32'h3333_3333, 0);
        tick();
        drive(0, '0, '0, 0, 1, 0, '0, 0);
        chk("ar_hold", f2d.valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("ar_valid", f2d.valid, 0);
        chk("ar_req", imem_req_valid, 0);
        chk("ar_pc", f2d.pc_word, 0);
        chk("ar_instr", f2d.instr, 0);
        #1 rst = 1'b0;
        tick();
        drive(0, '0, '0, 1, 1, 1, 32'h4444_4444, 0);
        chk("ar_ready", f2_ready, 1);
        tick();
        drive(0, '0, '0, 1, 1, 0, '0, 0);
        chk("ar_stray_rsp", f2d.valid, 0);

        // Randomized traffic against the transaction model
        busy = 0; have_req = 0; rsp_got = 0; rsp_cnt = 0;
        exp_pc = '0; exp_addr = '0; rsp_addr = '0;
        for (int c = 0; c < 1500; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            r  = $urandom;
            pc = r[29:0];
            r  = $urandom;
            addr = {r[31:2], 2'b00};
            dr = ($urandom_range(0, 9) < 7);
            rr = ($urandom_range(0, 9) < 6);
            rv = (rsp_cnt == 1);
            drive(v, pc, addr, dr, rr, rv, mem_word(rsp_addr), 0);

            chk("rnd_req_valid", imem_req_valid, busy && !have_req);
            if (busy && !have_req)
                chk("rnd_req_addr", imem_req_addr, exp_addr);
            chk("rnd_out_valid", f2d.valid, busy && rsp_got);
            chk("rnd_f2_ready", f2_ready, !busy || (rsp_got && dr));
            if (busy && rsp_got) begin
                w = mem_word(exp_addr);
                exp_instr = w[31:2];
                chk("rnd_pc", f2d.pc_word, exp_pc);
                chk("rnd_instr", f2d.instr, exp_instr);
            end

            consume = busy && rsp_got && dr;
            acc     = v && f2_ready;
            hs      = imem_req_valid && rr;
            if (rsp_cnt > 0) rsp_cnt--;
            if (hs) begin
                have_req = 1;
                rsp_cnt  = $urandom_range(1, 3);
                rsp_addr = imem_req_addr;
            end
            if (rv && busy && have_req) rsp_got = 1;
            if (consume) begin
                busy = 0; have_req = 0; rsp_got = 0;
            end
            if (acc) begin
                busy = 1; have_req = 0; rsp_got = 0;
                exp_pc = pc; exp_addr = addr;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
